// File: rtl/arb_pkg.sv
// Shared types and constants for the 2-master AXI4 memory arbiter.
//  arb_state_t : transaction FSM state, one state per AXI channel phase
//  AXI_*       : default bus widths used by axi_mem_arbiter
//  RESP_*      : AXI response codes (informational; responses pass through untouched)
package arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RADDR = 3'd1,
    S_RDATA = 3'd2,
    S_WADDR = 3'd3,
    S_WDATA = 3'd4,
    S_WRESP = 3'd5
  } arb_state_t;

  localparam int AXI_AW   = 32;
  localparam int AXI_DW   = 64;
  localparam int AXI_IW   = 4;
  localparam int AXI_LENW = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/arb_rr_pick.sv
// 2-way request picker, purely combinational.
//  req[1:0]    : request per master
//  last_winner : index of the previous winner (0 = m0, 1 = m1)
//  en_rr       : 1 -> ties go to the master that did not win last; 0 -> m0 wins ties
//  win[1:0]    : one-hot winner, 2'b00 when nothing requests
module arb_rr_pick (
  input  logic [1:0] req,
  input  logic       last_winner,
  input  logic       en_rr,
  output logic [1:0] win
);

  always_comb begin
    win = req;
    if (&req) win = (en_rr && !last_winner) ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/axi_mem_arbiter.sv
// 2-master -> 1-slave AXI4 arbiter: IFU (m0) and LSU/EXU (m1) share one memory port (s).
// One transaction in flight; grant latched in IDLE and held until the final R (rlast) or B
// handshake. Only the channel matching the current phase is connected; everything else
// sees valid/ready = 0.
// Ports:
//  clk, rst_n            : clock, synchronous active-low reset
//  m{0,1}_ar*/r*/aw*/w*/b* : master-side AXI4 bundles
//  s_ar*/r*/aw*/w*/b*    : slave-side AXI4 bundles
//  busy                  : transaction in flight
//  grant[1:0]            : one-hot owner, 2'b00 when idle
// Build option: ARB_ROUND_ROBIN_EN -> round-robin tie-break; otherwise m0 wins ties.
module axi_mem_arbiter
  import arb_pkg::*;
#(
  parameter int AW = AXI_AW,
  parameter int DW = AXI_DW,
  parameter int IW = AXI_IW
) (
  input  logic            clk,
  input  logic            rst_n,
  // master 0
  input  logic            m0_arvalid,
  output logic            m0_arready,
  input  logic [AW-1:0]   m0_araddr,
  input  logic [IW-1:0]   m0_arid,
  input  logic [7:0]      m0_arlen,
  input  logic [2:0]      m0_arsize,
  input  logic [1:0]      m0_arburst,
  output logic            m0_rvalid,
  input  logic            m0_rready,
  output logic [DW-1:0]   m0_rdata,
  output logic [1:0]      m0_rresp,
  output logic            m0_rlast,
  output logic [IW-1:0]   m0_rid,
  input  logic            m0_awvalid,
  output logic            m0_awready,
  input  logic [AW-1:0]   m0_awaddr,
  input  logic [IW-1:0]   m0_awid,
  input  logic [7:0]      m0_awlen,
  input  logic [2:0]      m0_awsize,
  input  logic [1:0]      m0_awburst,
  input  logic            m0_wvalid,
  output logic            m0_wready,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_wstrb,
  input  logic            m0_wlast,
  output logic            m0_bvalid,
  input  logic            m0_bready,
  output logic [1:0]      m0_bresp,
  output logic [IW-1:0]   m0_bid,
  // master 1
  input  logic            m1_arvalid,
  output logic            m1_arready,
  input  logic [AW-1:0]   m1_araddr,
  input  logic [IW-1:0]   m1_arid,
  input  logic [7:0]      m1_arlen,
  input  logic [2:0]      m1_arsize,
  input  logic [1:0]      m1_arburst,
  output logic            m1_rvalid,
  input  logic            m1_rready,
  output logic [DW-1:0]   m1_rdata,
  output logic [1:0]      m1_rresp,
  output logic            m1_rlast,
  output logic [IW-1:0]   m1_rid,
  input  logic            m1_awvalid,
  output logic            m1_awready,
  input  logic [AW-1:0]   m1_awaddr,
  input  logic [IW-1:0]   m1_awid,
  input  logic [7:0]      m1_awlen,
  input  logic [2:0]      m1_awsize,
  input  logic [1:0]      m1_awburst,
  input  logic            m1_wvalid,
  output logic            m1_wready,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_wstrb,
  input  logic            m1_wlast,
  output logic            m1_bvalid,
  input  logic            m1_bready,
  output logic [1:0]      m1_bresp,
  output logic [IW-1:0]   m1_bid,
  // slave
  output logic            s_arvalid,
  input  logic            s_arready,
  output logic [AW-1:0]   s_araddr,
  output logic [IW-1:0]   s_arid,
  output logic [7:0]      s_arlen,
  output logic [2:0]      s_arsize,
  output logic [1:0]      s_arburst,
  input  logic            s_rvalid,
  output logic            s_rready,
  input  logic [DW-1:0]   s_rdata,
  input  logic [1:0]      s_rresp,
  input  logic            s_rlast,
  input  logic [IW-1:0]   s_rid,
  output logic            s_awvalid,
  input  logic            s_awready,
  output logic [AW-1:0]   s_awaddr,
  output logic [IW-1:0]   s_awid,
  output logic [7:0]      s_awlen,
  output logic [2:0]      s_awsize,
  output logic [1:0]      s_awburst,
  output logic            s_wvalid,
  input  logic            s_wready,
  output logic [DW-1:0]   s_wdata,
  output logic [DW/8-1:0] s_wstrb,
  output logic            s_wlast,
  input  logic            s_bvalid,
  output logic            s_bready,
  input  logic [1:0]      s_bresp,
  input  logic [IW-1:0]   s_bid,
  // status
  output logic            busy,
  output logic [1:0]      grant
);

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic EN_RR = 1'b1;
`else
  localparam logic EN_RR = 1'b0;
`endif

  arb_state_t state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       lw_q, lw_d;   // last winner index; reset to m1 so m0 takes the first tie
  logic [1:0] req, win;

  assign req = {m1_arvalid | m1_awvalid, m0_arvalid | m0_awvalid};

  arb_rr_pick u_pick (
    .req         (req),
    .last_winner (lw_q),
    .en_rr       (EN_RR),
    .win         (win)
  );

  // Channel enables; gated by rst_n so every valid/ready drops in the reset cycle itself.
  logic ar_en, r_en, aw_en, w_en, b_en, g0, g1;
  assign ar_en = rst_n && (state_q == S_RADDR);
  assign r_en  = rst_n && (state_q == S_RDATA);
  assign aw_en = rst_n && (state_q == S_WADDR);
  assign w_en  = rst_n && (state_q == S_WDATA);
  assign b_en  = rst_n && (state_q == S_WRESP);
  assign g0    = grant_q[0];
  assign g1    = grant_q[1];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    lw_d    = lw_q;
    case (state_q)
      S_IDLE: if (|req) begin
        grant_d = win;
        // a winner with both AR and AW pending does its read first
        state_d = (win[1] ? m1_arvalid : m0_arvalid) ? S_RADDR : S_WADDR;
        if (EN_RR) lw_d = win[1];
      end
      S_RADDR: if (s_arvalid && s_arready) state_d = S_RDATA;
      S_RDATA: if (s_rvalid && s_rready && s_rlast) begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
      S_WADDR: if (s_awvalid && s_awready) state_d = S_WDATA;
      S_WDATA: if (s_wvalid && s_wready && s_wlast) state_d = S_WRESP;
      S_WRESP: if (s_bvalid && s_bready) begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= 2'b00;
      lw_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      lw_q    <= lw_d;
    end
  end

  assign busy  = rst_n && (state_q != S_IDLE);
  assign grant = rst_n ? grant_q : 2'b00;

  // AR
  assign s_arvalid  = ar_en & (g1 ? m1_arvalid : (g0 & m0_arvalid));
  assign s_araddr   = g1 ? m1_araddr  : g0 ? m0_araddr  : '0;
  assign s_arid     = g1 ? m1_arid    : g0 ? m0_arid    : '0;
  assign s_arlen    = g1 ? m1_arlen   : g0 ? m0_arlen   : '0;
  assign s_arsize   = g1 ? m1_arsize  : g0 ? m0_arsize  : '0;
  assign s_arburst  = g1 ? m1_arburst : g0 ? m0_arburst : '0;
  assign m0_arready = ar_en & g0 & s_arready;
  assign m1_arready = ar_en & g1 & s_arready;

  // R
  assign s_rready  = r_en & (g1 ? m1_rready : (g0 & m0_rready));
  assign m0_rvalid = r_en & g0 & s_rvalid;
  assign m1_rvalid = r_en & g1 & s_rvalid;
  assign m0_rdata  = g0 ? s_rdata : '0;
  assign m1_rdata  = g1 ? s_rdata : '0;
  assign m0_rresp  = g0 ? s_rresp : '0;
  assign m1_rresp  = g1 ? s_rresp : '0;
  assign m0_rlast  = g0 & s_rlast;
  assign m1_rlast  = g1 & s_rlast;
  assign m0_rid    = g0 ? s_rid : '0;
  assign m1_rid    = g1 ? s_rid : '0;

  // AW
  assign s_awvalid  = aw_en & (g1 ? m1_awvalid : (g0 & m0_awvalid));
  assign s_awaddr   = g1 ? m1_awaddr  : g0 ? m0_awaddr  : '0;
  assign s_awid     = g1 ? m1_awid    : g0 ? m0_awid    : '0;
  assign s_awlen    = g1 ? m1_awlen   : g0 ? m0_awlen   : '0;
  assign s_awsize   = g1 ? m1_awsize  : g0 ? m0_awsize  : '0;
  assign s_awburst  = g1 ? m1_awburst : g0 ? m0_awburst : '0;
  assign m0_awready = aw_en & g0 & s_awready;
  assign m1_awready = aw_en & g1 & s_awready;

  // W: only opens after the AW handshake
  assign s_wvalid  = w_en & (g1 ? m1_wvalid : (g0 & m0_wvalid));
  assign s_wdata   = g1 ? m1_wdata : g0 ? m0_wdata : '0;
  assign s_wstrb   = g1 ? m1_wstrb : g0 ? m0_wstrb : '0;
  assign s_wlast   = g1 ? m1_wlast : (g0 & m0_wlast);
  assign m0_wready = w_en & g0 & s_wready;
  assign m1_wready = w_en & g1 & s_wready;

  // B
  assign s_bready  = b_en & (g1 ? m1_bready : (g0 & m0_bready));
  assign m0_bvalid = b_en & g0 & s_bvalid;
  assign m1_bvalid = b_en & g1 & s_bvalid;
  assign m0_bresp  = g0 ? s_bresp : '0;
  assign m1_bresp  = g1 ? s_bresp : '0;
  assign m0_bid    = g0 ? s_bid : '0;
  assign m1_bid    = g1 ? s_bid : '0;

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter. Inputs change on the falling edge; outputs are
// sampled 1 time unit later, well away from the rising edge.
// Tie-break expectations follow ARB_ROUND_ROBIN_EN when the bench is built with it.
module tb_axi_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        m0_arvalid, m0_arready; logic [31:0] m0_araddr; logic [3:0] m0_arid;
  logic [7:0]  m0_arlen; logic [2:0] m0_arsize; logic [1:0] m0_arburst;
  logic        m0_rvalid, m0_rready; logic [63:0] m0_rdata; logic [1:0] m0_rresp;
  logic        m0_rlast; logic [3:0] m0_rid;
  logic        m0_awvalid, m0_awready; logic [31:0] m0_awaddr; logic [3:0] m0_awid;
  logic [7:0]  m0_awlen; logic [2:0] m0_awsize; logic [1:0] m0_awburst;
  logic        m0_wvalid, m0_wready; logic [63:0] m0_wdata; logic [7:0] m0_wstrb; logic m0_wlast;
  logic        m0_bvalid, m0_bready; logic [1:0] m0_bresp; logic [3:0] m0_bid;

  logic        m1_arvalid, m1_arready; logic [31:0] m1_araddr; logic [3:0] m1_arid;
  logic [7:0]  m1_arlen; logic [2:0] m1_arsize; logic [1:0] m1_arburst;
  logic        m1_rvalid, m1_rready; logic [63:0] m1_rdata; logic [1:0] m1_rresp;
  logic        m1_rlast; logic [3:0] m1_rid;
  logic        m1_awvalid, m1_awready; logic [31:0] m1_awaddr; logic [3:0] m1_awid;
  logic [7:0]  m1_awlen; logic [2:0] m1_awsize; logic [1:0] m1_awburst;
  logic        m1_wvalid, m1_wready; logic [63:0] m1_wdata; logic [7:0] m1_wstrb; logic m1_wlast;
  logic        m1_bvalid, m1_bready; logic [1:0] m1_bresp; logic [3:0] m1_bid;

  logic        s_arvalid, s_arready; logic [31:0] s_araddr; logic [3:0] s_arid;
  logic [7:0]  s_arlen; logic [2:0] s_arsize; logic [1:0] s_arburst;
  logic        s_rvalid, s_rready; logic [63:0] s_rdata; logic [1:0] s_rresp;
  logic        s_rlast; logic [3:0] s_rid;
  logic        s_awvalid, s_awready; logic [31:0] s_awaddr; logic [3:0] s_awid;
  logic [7:0]  s_awlen; logic [2:0] s_awsize; logic [1:0] s_awburst;
  logic        s_wvalid, s_wready; logic [63:0] s_wdata; logic [7:0] s_wstrb; logic s_wlast;
  logic        s_bvalid, s_bready; logic [1:0] s_bresp; logic [3:0] s_bid;

  logic        busy;
  logic [1:0]  grant;

  axi_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arid(m0_arid),
    .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
    .m0_rlast(m0_rlast), .m0_rid(m0_rid),
    .m0_awvalid(m0_awvalid), .m0_awready(m0_awready), .m0_awaddr(m0_awaddr), .m0_awid(m0_awid),
    .m0_awlen(m0_awlen), .m0_awsize(m0_awsize), .m0_awburst(m0_awburst),
    .m0_wvalid(m0_wvalid), .m0_wready(m0_wready), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_wlast(m0_wlast),
    .m0_bvalid(m0_bvalid), .m0_bready(m0_bready), .m0_bresp(m0_bresp), .m0_bid(m0_bid),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_arid(m1_arid),
    .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
    .m1_rlast(m1_rlast), .m1_rid(m1_rid),
    .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr), .m1_awid(m1_awid),
    .m1_awlen(m1_awlen), .m1_awsize(m1_awsize), .m1_awburst(m1_awburst),
    .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_wlast(m1_wlast),
    .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp), .m1_bid(m1_bid),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rid(s_rid),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid),
    .busy(busy), .grant(grant)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int nbeats;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    m0_arvalid = 0; m0_araddr = 0; m0_arid = 0; m0_arlen = 0; m0_arsize = 3; m0_arburst = 1;
    m0_rready = 0; m0_awvalid = 0; m0_awaddr = 0; m0_awid = 0; m0_awlen = 0; m0_awsize = 3;
    m0_awburst = 1; m0_wvalid = 0; m0_wdata = 0; m0_wstrb = 0; m0_wlast = 0; m0_bready = 0;
    m1_arvalid = 0; m1_araddr = 0; m1_arid = 0; m1_arlen = 0; m1_arsize = 3; m1_arburst = 1;
    m1_rready = 0; m1_awvalid = 0; m1_awaddr = 0; m1_awid = 0; m1_awlen = 0; m1_awsize = 3;
    m1_awburst = 1; m1_wvalid = 0; m1_wdata = 0; m1_wstrb = 0; m1_wlast = 0; m1_bready = 0;
    s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0; s_rlast = 0; s_rid = 0;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0; s_bid = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); clr_in(); rst_n = 0;
    @(negedge clk); rst_n = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clr_in();
    rst_n = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_s_arvalid", s_arvalid, 0);
    chk("rst_s_awvalid", s_awvalid, 0);
    rst_n = 1;

    // lone m0 read, len 0
    @(negedge clk);
    m0_arvalid = 1; m0_araddr = 32'h8000_0000; m0_arid = 4'h3; m0_arlen = 0;
    #1 chk("t1_idle_no_arvalid", s_arvalid, 0);
    @(negedge clk); #1;
    chk("t1_grant", grant, 2'b01);
    chk("t1_busy", busy, 1);
    chk("t1_s_arvalid", s_arvalid, 1);
    chk("t1_s_araddr", s_araddr, 32'h8000_0000);
    chk("t1_s_arid", s_arid, 4'h3);
    s_arready = 1;
    #1 chk("t1_m0_arready", m0_arready, 1);
    chk("t1_m1_arready", m1_arready, 0);
    @(negedge clk);
    m0_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rdata = 64'h1122_3344_5566_7788; s_rlast = 1; s_rid = 4'h3;
    m0_rready = 1; m1_rready = 1;
    #1 chk("t1_m0_rvalid", m0_rvalid, 1);
    chk("t1_m0_rdata", m0_rdata, 64'h1122_3344_5566_7788);
    chk("t1_m0_rid", m0_rid, 4'h3);
    chk("t1_m1_rvalid", m1_rvalid, 0);
    chk("t1_s_rready", s_rready, 1);
    @(negedge clk);
    s_rvalid = 0; s_rlast = 0; m0_rready = 0; m1_rready = 0;
    #1 chk("t1_end_busy", busy, 0);
    chk("t1_end_grant", grant, 0);

    // tie: m0 AR vs m1 AW, twice
    do_reset();
    m0_arvalid = 1; m0_araddr = 32'h0000_1000;
    m1_awvalid = 1; m1_awaddr = 32'h0000_2000;
    @(negedge clk); #1;
    chk("t2_tie1_grant", grant, 2'b01);
    chk("t2_tie1_s_arvalid", s_arvalid, 1);
    chk("t2_tie1_s_awvalid", s_awvalid, 0);
    s_arready = 1;
    @(negedge clk);
    s_arready = 0; m0_araddr = 32'h0000_1040;
    s_rvalid = 1; s_rlast = 1; m0_rready = 1;
    @(negedge clk);
    s_rvalid = 0; s_rlast = 0; m0_rready = 0;
    #1 chk("t2_gap_busy", busy, 0);
    @(negedge clk); #1;
`ifdef ARB_ROUND_ROBIN_EN
    chk("t2_tie2_grant", grant, 2'b10);
    chk("t2_tie2_s_awvalid", s_awvalid, 1);
    chk("t2_tie2_s_awaddr", s_awaddr, 32'h0000_2000);
    chk("t2_tie2_s_arvalid", s_arvalid, 0);
`else
    chk("t2_tie2_grant", grant, 2'b01);
    chk("t2_tie2_s_arvalid", s_arvalid, 1);
    chk("t2_tie2_s_araddr", s_araddr, 32'h0000_1040);
    chk("t2_tie2_s_awvalid", s_awvalid, 0);
`endif

    // m1 write len 3; W held off while AW stalls 5 cycles
    do_reset();
    m1_awvalid = 1; m1_awaddr = 32'h3000_0000; m1_awlen = 8'd3; m1_awid = 4'h5;
    m1_wvalid = 1; m1_wdata = 64'h100; m1_wstrb = 8'h0F; m1_bready = 1;
    @(negedge clk); #1;
    chk("t3_grant", grant, 2'b10);
    chk("t3_s_awlen", s_awlen, 8'd3);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_s_wvalid_blocked", s_wvalid, 0);
      chk("t4_m1_wready_blocked", m1_wready, 0);
      chk("t4_s_awvalid_held", s_awvalid, 1);
      @(negedge clk);
    end
    s_awready = 1;
    #1 chk("t3_m1_awready", m1_awready, 1);
    @(negedge clk);
    m1_awvalid = 0; s_awready = 0; s_wready = 1;
    nbeats = 0;
    for (int b = 0; b < 4; b++) begin
      m1_wdata = 64'h100 + 64'(b); m1_wlast = (b == 3);
      #1;
      chk("t3_s_wvalid", s_wvalid, 1);
      chk("t3_s_wdata", s_wdata, 64'h100 + 64'(b));
      chk("t3_s_wstrb", s_wstrb, 8'h0F);
      chk("t3_s_wlast", s_wlast, (b == 3));
      chk("t3_m1_wready", m1_wready, 1);
      chk("t3_m0_wready", m0_wready, 0);
      if (s_wvalid && s_wready) nbeats++;
      @(negedge clk);
    end
    m1_wlast = 0; m1_wdata = 64'h104;
    #1 chk("t3_no_5th_beat", s_wvalid, 0);
    chk("t3_wresp_wready", m1_wready, 0);
    chk("t3_beats", nbeats, 4);
    chk("t3_wresp_busy", busy, 1);
    m1_wvalid = 0; s_wready = 0;
    s_bvalid = 1; s_bresp = 2'b00; s_bid = 4'h5;
    #1 chk("t3_m1_bvalid", m1_bvalid, 1);
    chk("t3_m1_bid", m1_bid, 4'h5);
    chk("t3_m0_bvalid", m0_bvalid, 0);
    chk("t3_s_bready", s_bready, 1);
    @(negedge clk);
    s_bvalid = 0;
    #1 chk("t3_end_busy", busy, 0);
    chk("t3_end_grant", grant, 0);

    // SLVERR on beat 2 of a len-1 read passes through; stray R held off in RADDR
    @(negedge clk);
    m0_arvalid = 1; m0_araddr = 32'h0000_4000; m0_arlen = 8'd1; m0_rready = 1; m1_bready = 0;
    @(negedge clk);
    s_rvalid = 1;
    #1 chk("t5_r_held_off", s_rready, 0);
    chk("t5_m0_rvalid_off", m0_rvalid, 0);
    s_rvalid = 0; s_arready = 1;
    @(negedge clk);
    m0_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rdata = 64'hA; s_rresp = 2'b00; s_rlast = 0;
    #1 chk("t5_beat1_resp", m0_rresp, 2'b00);
    chk("t5_beat1_rvalid", m0_rvalid, 1);
    @(negedge clk);
    s_rdata = 64'hB; s_rresp = 2'b10; s_rlast = 1;
    #1 chk("t5_beat2_resp", m0_rresp, 2'b10);
    chk("t5_beat2_rlast", m0_rlast, 1);
    chk("t5_beat2_busy", busy, 1);
    @(negedge clk);
    s_rvalid = 0; s_rlast = 0; s_rresp = 0;
    #1 chk("t5_end_busy", busy, 0);

    // reset during beat 2 of a len-3 read
    @(negedge clk);
    m0_arvalid = 1; m0_arlen = 8'd3; m0_rready = 1;
    @(negedge clk);
    s_arready = 1;
    @(negedge clk);
    m0_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rdata = 64'h1; s_rlast = 0;
    @(negedge clk);
    s_rdata = 64'h2; rst_n = 0;
    #1 chk("t6_rst_cycle_rvalid", m0_rvalid, 0);
    chk("t6_rst_cycle_rready", s_rready, 0);
    @(negedge clk);
    rst_n = 1;
    #1 chk("t6_busy", busy, 0);
    chk("t6_grant", grant, 0);
    chk("t6_s_rready", s_rready, 0);
    chk("t6_m0_rvalid", m0_rvalid, 0);
    chk("t6_s_arvalid", s_arvalid, 0);
    clr_in();

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
